// File: rtl/note_select.sv
// Key front end: synchronise and debounce 12 semitone keys, pick the last-pressed note, register its frequency.
// Optional sustain behaviour is compiled in with `define NOTE_HOLD_EN.
module note_select #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] key_raw,
   input  logic        hold,
   output logic [11:0] freq,
   output logic [3:0]  note_idx,
   output logic        note_on,
   output logic        note_change
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [11:0] sync1_reg;
   logic [11:0] sync2_reg;
   logic [11:0] key_s;
   logic [11:0] stable;
   logic [11:0] stable_d_reg;
   logic [11:0] press;
   logic [11:0] rel;

   logic [11:0] freq_reg, freq_next;
   logic [3:0]  note_idx_reg, note_idx_next;
   logic        note_on_reg, note_on_next;
   logic        note_change_reg, note_change_next;

   logic        active_rel;
   logic        drop;
   logic        keep;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
      end else begin
         sync1_reg <= key_raw;
         sync2_reg <= sync1_reg;
      end
   end

   assign key_s = sync2_reg;

   genvar gi;
   generate
      for (gi = 0; gi < 12; gi++) begin : g_key
         logic [CNT_W-1:0] cnt_reg;
         logic             stable_reg;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt_reg    <= '0;
               stable_reg <= 1'b0;
            end else if (key_s[gi] == stable_reg) begin
               cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
               stable_reg <= key_s[gi];
               cnt_reg    <= '0;
            end else begin
               cnt_reg <= cnt_reg + CNT_W'(1);
            end
         end

         assign stable[gi] = stable_reg;
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stable_d_reg <= '0;
      else        stable_d_reg <= stable;
   end

   assign press = stable & ~stable_d_reg;
   assign rel   = ~stable & stable_d_reg;

   function automatic logic [3:0] lowest(input logic [11:0] v);
      logic [3:0] r;
      r = '0;
      for (int i = 11; i >= 0; i--) begin
         if (v[i]) r = 4'(i);
      end
      return r;
   endfunction

   function automatic logic [11:0] freq_lut(input logic [3:0] idx);
      logic [11:0] f;
      case (idx)
         4'd0:    f = 12'd261;
         4'd1:    f = 12'd277;
         4'd2:    f = 12'd293;
         4'd3:    f = 12'd311;
         4'd4:    f = 12'd330;
         4'd5:    f = 12'd349;
         4'd6:    f = 12'd370;
         4'd7:    f = 12'd392;
         4'd8:    f = 12'd415;
         4'd9:    f = 12'd440;
         4'd10:   f = 12'd466;
         4'd11:   f = 12'd494;
         default: f = 12'd0;
      endcase
      return f;
   endfunction

   // The registered note index doubles as the active-key state.
   assign active_rel = note_on_reg && rel[note_idx_reg];

`ifdef NOTE_HOLD_EN
   // A sustained note (its key no longer down) is dropped as soon as hold goes low.
   assign drop = active_rel || (note_on_reg && !stable[note_idx_reg] && !hold);
   assign keep = hold;
`else
   logic unused_hold;
   assign unused_hold = hold;
   assign drop = active_rel;
   assign keep = 1'b0;
`endif

   always_comb begin
      note_on_next  = note_on_reg;
      note_idx_next = note_idx_reg;
      if (|press) begin
         note_on_next  = 1'b1;
         note_idx_next = lowest(press);
      end else if (drop) begin
         if (|stable) begin
            note_on_next  = 1'b1;
            note_idx_next = lowest(stable);
         end else if (!keep) begin
            note_on_next  = 1'b0;
            note_idx_next = '0;
         end
      end
      freq_next        = note_on_next ? freq_lut(note_idx_next) : 12'd0;
      note_change_next = (freq_next != freq_reg);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         freq_reg        <= '0;
         note_idx_reg    <= '0;
         note_on_reg     <= 1'b0;
         note_change_reg <= 1'b0;
      end else begin
         freq_reg        <= freq_next;
         note_idx_reg    <= note_idx_next;
         note_on_reg     <= note_on_next;
         note_change_reg <= note_change_next;
      end
   end

   assign freq        = freq_reg;
   assign note_idx    = note_idx_reg;
   assign note_on     = note_on_reg;
   assign note_change = note_change_reg;

endmodule

// File: tb/tb_note_select.sv
// Directed bench for note_select with a 4-cycle debounce: table of key patterns plus hand-written corner sequences.
module tb_note_select;

   localparam int DEB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [11:0] key_raw = '0;
   logic        hold = 1'b0;
   logic [11:0] freq;
   logic [3:0]  note_idx;
   logic        note_on;
   logic        note_change;

   note_select #(.DEBOUNCE_CYCLES(DEB), .CNT_W(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_raw     (key_raw),
      .hold        (hold),
      .freq        (freq),
      .note_idx    (note_idx),
      .note_on     (note_on),
      .note_change (note_change)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [11:0] keys;
      int          f;
      int          idx;
      int          on;
      int          pulses;
   } vec_t;

   vec_t tbl[13];
   int   vecs = 0;
   int   errs = 0;
   int   pulses = 0;
   int   last_freq = 0;

   task automatic chk(input string name, input int act, input int exp);
      vecs++;
      if (act != exp) begin
         errs++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (note_change) pulses++;
   endtask

   // Drive a key pattern, expect no output change on edge 6 and the new note on edge 7.
   task automatic run_vec(input string tag, input logic [11:0] k, input logic h,
                          input int ef, input int ei, input int eon, input int ep);
      key_raw = k;
      hold    = h;
      pulses  = 0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (e == 6) chk({tag, "_edge6_freq"}, int'(freq), last_freq);
         if (e == 7) begin
            chk({tag, "_freq"}, int'(freq), ef);
            chk({tag, "_idx"}, int'(note_idx), ei);
            chk({tag, "_on"}, int'(note_on), eon);
         end
      end
      chk({tag, "_pulses"}, pulses, ep);
      $display("vec %s keys=%03h freq=%0d idx=%0d on=%0d pulses=%0d", tag, k, freq, note_idx, note_on, pulses);
      last_freq = ef;
   endtask

   initial begin
      tbl[0]  = '{"k9_press",   12'h200, 440, 9,  1, 1};
      tbl[1]  = '{"k9_rel",     12'h000, 0,   0,  0, 1};
      tbl[2]  = '{"k0_press",   12'h001, 261, 0,  1, 1};
      tbl[3]  = '{"k11_press",  12'h801, 494, 11, 1, 1};
      tbl[4]  = '{"k11_rel",    12'h001, 261, 0,  1, 1};
      tbl[5]  = '{"k0_rel",     12'h000, 0,   0,  0, 1};
      tbl[6]  = '{"k2k7_press", 12'h084, 293, 2,  1, 1};
      tbl[7]  = '{"k2k7_rel",   12'h000, 0,   0,  0, 1};
      tbl[8]  = '{"k5_press",   12'h020, 349, 5,  1, 1};
      tbl[9]  = '{"k3_press",   12'h028, 311, 3,  1, 1};
      tbl[10] = '{"k3_rel",     12'h020, 349, 5,  1, 1};
      tbl[11] = '{"k8_press",   12'h120, 415, 8,  1, 1};
      tbl[12] = '{"k5_rel_na",  12'h100, 415, 8,  1, 0};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_freq", int'(freq), 0);
      chk("rst_idx", int'(note_idx), 0);
      chk("rst_on", int'(note_on), 0);
      chk("rst_change", int'(note_change), 0);
      rst_n = 1'b1;
      tick();

      foreach (tbl[i]) begin
         run_vec(tbl[i].tag, tbl[i].keys, 1'b0, tbl[i].f, tbl[i].idx, tbl[i].on, tbl[i].pulses);
      end
      run_vec("all_rel", 12'h000, 1'b0, 0, 0, 0, 1);

      // Glitch shorter than the debounce window
      pulses  = 0;
      key_raw = 12'h010;
      repeat (3) tick();
      key_raw = 12'h000;
      repeat (9) tick();
      chk("glitch_freq", int'(freq), 0);
      chk("glitch_pulses", pulses, 0);
      $display("seq glitch freq=%0d pulses=%0d", freq, pulses);

      // Reset in the middle of key 1's debounce while key 9 is playing
      run_vec("k9_again", 12'h200, 1'b0, 440, 9, 1, 1);
      key_raw = 12'h202;
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_freq", int'(freq), 0);
      chk("midrst_idx", int'(note_idx), 0);
      chk("midrst_on", int'(note_on), 0);
      chk("midrst_change", int'(note_change), 0);
      repeat (2) tick();
      rst_n  = 1'b1;
      pulses = 0;
      for (int e = 1; e <= 12; e++) begin
         tick();
         if (e == 6) chk("postrst_edge6_freq", int'(freq), 0);
         if (e == 7) begin
            chk("postrst_freq", int'(freq), 277);
            chk("postrst_idx", int'(note_idx), 1);
            chk("postrst_on", int'(note_on), 1);
         end
      end
      chk("postrst_pulses", pulses, 1);
      $display("seq midreset freq=%0d idx=%0d pulses=%0d", freq, note_idx, pulses);
      last_freq = 277;
      run_vec("rel_1_9", 12'h000, 1'b0, 0, 0, 0, 1);

      // Sustain behaviour
      run_vec("h_press6", 12'h040, 1'b1, 370, 6, 1, 1);
`ifdef NOTE_HOLD_EN
      run_vec("h_rel6", 12'h000, 1'b1, 370, 6, 1, 0);
      pulses = 0;
      hold   = 1'b0;
      tick();
      chk("h_drop_freq", int'(freq), 0);
      chk("h_drop_on", int'(note_on), 0);
      chk("h_drop_pulses", pulses, 1);
`else
      run_vec("h_rel6", 12'h000, 1'b1, 0, 0, 0, 1);
      pulses = 0;
      hold   = 1'b0;
      tick();
      chk("h_drop_freq", int'(freq), 0);
      chk("h_drop_on", int'(note_on), 0);
      chk("h_drop_pulses", pulses, 0);
`endif
      $display("seq hold_drop freq=%0d on=%0d pulses=%0d", freq, note_on, pulses);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/note_select.md
Name: note_select

Overview:
- Front-end stage that turns 12 raw key inputs (one per semitone, C to B) into the 12-bit note frequency consumed by the 7-segment note display and the tone generator.
- Synchronises and debounces every key.
- Resolves the keys with last-pressed priority.
- Outputs a registered frequency code plus note status.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable synchronised cycles required before a key's debounced state flips. This is 10 ms at 100 MHz. Legal range is 2 to 2^CNT_W-1.
- CNT_W, 20: width of each per-key debounce counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- key_raw  input  12  raw key levels, 1 = pressed. Bit 0 = C, bit 11 = B. Asynchronous to clk.
- hold  input  1  sustain request. Used only when NOTE_HOLD_EN is defined, otherwise ignored.
- freq  output  12  frequency code in Hz of the active note. 0 = silence.
- note_idx  output  4  index 0..11 of the active note. 0 when silent.
- note_on  output  1  1 while a note is active.
- note_change  output  1  single-cycle pulse on any change of freq.

Behaviour:
- Clocking: one clock, reset asynchronous and active-low. All flops reset on rst_n low, regardless of clk.
- Reset values: freq=0, note_idx=0, note_on=0, note_change=0. All sync flops, debounced states and counters are 0. Active key = none.
- Synchroniser: a two-flop synchroniser per key_raw bit produces key_s.
- Debounce, per key:
  - if key_s == stable: cnt <= 0.
  - else if cnt == DEBOUNCE_CYCLES-1: stable <= key_s and cnt <= 0.
  - else: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable.
- Edge detect: press = stable rising and release = stable falling, each for one cycle.
- Active-key arbitration, evaluated every cycle:
  - One or more presses this cycle: the lowest-index pressed key becomes active.
  - Otherwise, if the active key is released: the lowest-index key still stable-high becomes active, or none if no key is held.
  - Release of a non-active key: no change.
  - Press and release of different keys in the same cycle: the press rule wins.
- Frequency table, indices 0..11: 261, 277, 293, 311, 330, 349, 370, 392, 415, 440, 466, 494. No active key gives freq=0.
- Output register: freq, note_idx and note_on update one cycle after the arbitration decision.
  - note_change is high for exactly that cycle whenever the new freq differs from the old one.
  - Re-selecting the same note produces no pulse.
- Latency: a key_raw edge held steady appears on freq on the (DEBOUNCE_CYCLES+3)th rising clk edge after the raw edge. That is 2 sync + DEBOUNCE_CYCLES debounce + 1 output register.
- Reset mid-debounce: the counter clears. After rst_n rises, a held key requires a full fresh debounce before it is seen.

Optional Feature:
- Macro NOTE_HOLD_EN.
- Defined: when all keys are released while hold=1, the last active note is kept.
  - freq, note_idx and note_on=1 are held.
  - Dropping hold to 0 with no key held silences the output on the next arbitration cycle.
  - A new press always overrides the held note.
- Undefined: the hold input is ignored, and releasing all keys silences the output as in the base rules.

Test Plan (DEBOUNCE_CYCLES=4 throughout):
- Reset -> freq=0, note_idx=0, note_on=0, note_change=0. Press key 9 and hold -> freq=440, note_idx=9, note_on=1 on the 7th edge after the press, with one note_change pulse.
- Pulse key 4 high for 3 cycles -> freq stays 0 and there is no note_change.
- Hold key 0 (261), then press key 11 -> freq=494. Release key 11 -> freq=261. Release key 0 -> freq=0 and note_on=0, with a pulse at each step.
- Keys 2 and 7 pressed in the same cycle -> freq=293 and note_idx=2.
- Hold key 5 (349), press and release key 3 while key 5 stays held -> freq goes 311 then back to 349.
- Assert rst_n low mid-debounce of key 1 -> outputs return to reset values. After release of reset with key 1 still held -> freq=277 on the 7th edge.
- With NOTE_HOLD_EN defined: hold=1, press then release key 6 -> freq stays 370. Drop hold to 0 -> freq=0.
